// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared widths and FSM state encodings for io_bus_arbiter.
//   IO_ADDR_W / IO_DATA_W / IO_BE_W  - I/O bus widths (word address, data, byte enables)
//   WAIT_CNT_W                       - width of the settle-window down-counter
//   arb_state_t, St*                 - sequencer states (legacy localparam encoding)
package io_arb_pkg;

  localparam int unsigned IO_ADDR_W  = 11;
  localparam int unsigned IO_DATA_W  = 32;
  localparam int unsigned IO_BE_W    = 4;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle   = 2'd0;
  localparam arb_state_t StStrobe = 2'd1;
  localparam arb_state_t StWait   = 2'd2;
  localparam arb_state_t StDone   = 2'd3;

endpackage

// File: rtl/io_arb_rr.sv
// io_arb_rr: purely combinational 2-way round-robin pick.
//   req_i[1:0]    - request per master
//   last_grant_i  - master granted most recently (0 or 1)
//   lock_valid_i  - a bus lock is in force; only lock_owner_i may be granted
//   lock_owner_i  - master holding the lock
//   gnt_o[1:0]    - one-hot grant (all zero when nothing is grantable)
module io_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       lock_valid_i,
  input  logic       lock_owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (lock_valid_i) begin
      // Locked: the other master waits even if the owner is not requesting.
      gnt_o[lock_owner_i] = req_i[lock_owner_i];
    end else if (req_i == 2'b11) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master round-robin arbiter and access sequencer for the I/O register bus.
// Each granted access issues exactly one strobe cycle, holds address/data/be for WAIT_CYCLES
// settle cycles, then captures io_data_in into the winner's data_out and pulses its ack.
//   Parameter WAIT_CYCLES (0..15)  - settle cycles between strobe and read-data capture
//   clk, rst_n                     - clock, asynchronous active-low reset
//   m{0,1}_read/_write/_address/_data_in/_be  - master requests (held until ack)
//   m{0,1}_data_out/_ack           - read data and completion pulse
//   m{0,1}_lock                    - bus lock request (only when IOARB_LOCK_EN is defined)
//   io_read/_write/_address/_data_out/_be     - registered bus outputs to the I/O controller
//   io_data_in                     - read data from the I/O controller
// Optional feature macro: IOARB_LOCK_EN.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 m0_read,
  input  logic                 m0_write,
  input  logic [IO_ADDR_W-1:0] m0_address,
  input  logic [IO_DATA_W-1:0] m0_data_in,
  input  logic [IO_BE_W-1:0]   m0_be,
  output logic [IO_DATA_W-1:0] m0_data_out,
  output logic                 m0_ack,

  input  logic                 m1_read,
  input  logic                 m1_write,
  input  logic [IO_ADDR_W-1:0] m1_address,
  input  logic [IO_DATA_W-1:0] m1_data_in,
  input  logic [IO_BE_W-1:0]   m1_be,
  output logic [IO_DATA_W-1:0] m1_data_out,
  output logic                 m1_ack,

`ifdef IOARB_LOCK_EN
  input  logic                 m0_lock,
  input  logic                 m1_lock,
`endif

  output logic                 io_read,
  output logic                 io_write,
  output logic [IO_ADDR_W-1:0] io_address,
  output logic [IO_DATA_W-1:0] io_data_out,
  output logic [IO_BE_W-1:0]   io_be,
  input  logic [IO_DATA_W-1:0] io_data_in
);

  // Counter is loaded on WAIT entry so that WAIT lasts exactly WAIT_CYCLES cycles.
  localparam logic [WAIT_CNT_W-1:0] WaitLoad =
      (WAIT_CYCLES == 0) ? '0 : 4'(WAIT_CYCLES - 1);

  arb_state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]       cnt_q, cnt_d;
  logic                        last_grant_q, last_grant_d;
  logic                        owner_q, owner_d;
  logic                        io_read_q, io_read_d;
  logic                        io_write_q, io_write_d;
  logic [IO_ADDR_W-1:0]        io_addr_q, io_addr_d;
  logic [IO_DATA_W-1:0]        io_wdata_q, io_wdata_d;
  logic [IO_BE_W-1:0]          io_be_q, io_be_d;
  logic [1:0]                  ack_q, ack_d;
  logic [IO_DATA_W-1:0]        rdata0_q, rdata0_d;
  logic [IO_DATA_W-1:0]        rdata1_q, rdata1_d;

  logic [1:0]                  req;
  logic [1:0]                  gnt;
  logic                        enter_done;
  logic                        rr_lock_valid;
  logic                        rr_lock_owner;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  io_arb_rr u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .lock_valid_i (rr_lock_valid),
    .lock_owner_i (rr_lock_owner),
    .gnt_o        (gnt)
  );

`ifdef IOARB_LOCK_EN
  logic lock_valid_q, lock_valid_d;
  logic lock_owner_q, lock_owner_d;
  logic owner_lock;

  // Lock input of whichever master currently holds the lock.
  assign owner_lock    = lock_owner_q ? m1_lock : m0_lock;
  // A lock only constrains arbitration while its owner keeps it high in IDLE.
  assign rr_lock_valid = lock_valid_q & owner_lock;
  assign rr_lock_owner = lock_owner_q;

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (state_q == StIdle && lock_valid_q && !owner_lock) begin
      lock_valid_d = 1'b0;
    end
    if (state_q == StDone) begin
      lock_valid_d = owner_q ? m1_lock : m0_lock;
      lock_owner_d = owner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  assign rr_lock_valid = 1'b0;
  assign rr_lock_owner = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    io_read_d    = 1'b0;
    io_write_d   = 1'b0;
    io_addr_d    = io_addr_q;
    io_wdata_d   = io_wdata_q;
    io_be_d      = io_be_q;
    ack_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    enter_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          state_d      = StStrobe;
          owner_d      = gnt[1];
          last_grant_d = gnt[1];
          // Write takes precedence when both read and write are high.
          if (gnt[1]) begin
            io_addr_d  = m1_address;
            io_wdata_d = m1_data_in;
            io_be_d    = m1_be;
            io_write_d = m1_write;
            io_read_d  = ~m1_write;
          end else begin
            io_addr_d  = m0_address;
            io_wdata_d = m0_data_in;
            io_be_d    = m0_be;
            io_write_d = m0_write;
            io_read_d  = ~m0_write;
          end
        end
      end
      StStrobe: begin
        if (WAIT_CYCLES > 0) begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end else begin
          enter_done = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Ack and read data are registered on DONE entry so both are valid during DONE.
    if (enter_done) begin
      state_d        = StDone;
      ack_d[owner_q] = 1'b1;
      if (owner_q) begin
        rdata1_d = io_data_in;
      end else begin
        rdata0_d = io_data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      io_read_q    <= 1'b0;
      io_write_q   <= 1'b0;
      io_addr_q    <= '0;
      io_wdata_q   <= '0;
      io_be_q      <= '0;
      ack_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      io_read_q    <= io_read_d;
      io_write_q   <= io_write_d;
      io_addr_q    <= io_addr_d;
      io_wdata_q   <= io_wdata_d;
      io_be_q      <= io_be_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign io_read     = io_read_q;
  assign io_write    = io_write_q;
  assign io_address  = io_addr_q;
  assign io_data_out = io_wdata_q;
  assign io_be       = io_be_q;
  assign m0_ack      = ack_q[0];
  assign m1_ack      = ack_q[1];
  assign m0_data_out = rdata0_q;
  assign m1_data_out = rdata1_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed self-checking bench for io_bus_arbiter.
// Instantiates a default (WAIT_CYCLES=2) DUT and a WAIT_CYCLES=0 DUT. Inputs are driven and
// outputs sampled on the falling clock edge. Lock scenario runs only with IOARB_LOCK_EN.
module tb_io_bus_arbiter;

  logic        clk;
  logic        rst_n;

  logic        m0_read, m0_write, m1_read, m1_write;
  logic [10:0] m0_address, m1_address;
  logic [31:0] m0_data_in, m1_data_in;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_data_out, m1_data_out;
  logic        m0_ack, m1_ack;
  logic        io_read, io_write;
  logic [10:0] io_address;
  logic [31:0] io_data_out;
  logic [3:0]  io_be;
  logic [31:0] io_data_in;

  logic        z_m0_read;
  logic [10:0] z_m0_address;
  logic [31:0] z_m0_data_out, z_m1_data_out;
  logic        z_m0_ack, z_m1_ack;
  logic        z_io_read, z_io_write;
  logic [10:0] z_io_address;
  logic [31:0] z_io_data_out;
  logic [3:0]  z_io_be;
  logic [31:0] z_io_data_in;

  logic        din_mode;
  logic [31:0] din_v;

`ifdef IOARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  int passed;
  int total;
  int strobes;

  // Address-derived read data lets each captured value identify which access produced it.
  assign io_data_in   = din_mode ? (32'h5A00_0000 | {21'h0, io_address}) : din_v;
  assign z_io_data_in = 32'h5A00_0000 | {21'h0, z_io_address};

  io_bus_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_read     (m0_read),
    .m0_write    (m0_write),
    .m0_address  (m0_address),
    .m0_data_in  (m0_data_in),
    .m0_be       (m0_be),
    .m0_data_out (m0_data_out),
    .m0_ack      (m0_ack),
    .m1_read     (m1_read),
    .m1_write    (m1_write),
    .m1_address  (m1_address),
    .m1_data_in  (m1_data_in),
    .m1_be       (m1_be),
    .m1_data_out (m1_data_out),
    .m1_ack      (m1_ack),
`ifdef IOARB_LOCK_EN
    .m0_lock     (m0_lock),
    .m1_lock     (m1_lock),
`endif
    .io_read     (io_read),
    .io_write    (io_write),
    .io_address  (io_address),
    .io_data_out (io_data_out),
    .io_be       (io_be),
    .io_data_in  (io_data_in)
  );

  io_bus_arbiter #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_read     (z_m0_read),
    .m0_write    (1'b0),
    .m0_address  (z_m0_address),
    .m0_data_in  (32'h0),
    .m0_be       (4'h0),
    .m0_data_out (z_m0_data_out),
    .m0_ack      (z_m0_ack),
    .m1_read     (1'b0),
    .m1_write    (1'b0),
    .m1_address  (11'h0),
    .m1_data_in  (32'h0),
    .m1_be       (4'h0),
    .m1_data_out (z_m1_data_out),
    .m1_ack      (z_m1_ack),
`ifdef IOARB_LOCK_EN
    .m0_lock     (1'b0),
    .m1_lock     (1'b0),
`endif
    .io_read     (z_io_read),
    .io_write    (z_io_write),
    .io_address  (z_io_address),
    .io_data_out (z_io_data_out),
    .io_be       (z_io_be),
    .io_data_in  (z_io_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_data_in = '0; m0_be = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_data_in = '0; m1_be = '0;
    z_m0_read = 1'b0; z_m0_address = '0;
    din_mode = 1'b0; din_v = '0;
`ifdef IOARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_io_read",  32'(io_read), 32'h0);
    check("rst_io_write", 32'(io_write), 32'h0);
    check("rst_io_addr",  32'(io_address), 32'h0);
    check("rst_io_dout",  io_data_out, 32'h0);
    check("rst_io_be",    32'(io_be), 32'h0);
    check("rst_acks",     32'({m1_ack, m0_ack}), 32'h0);
    check("rst_m0_dout",  m0_data_out, 32'h0);
    check("rst_m1_dout",  m1_data_out, 32'h0);
    rst_n = 1'b1;

    // Single read by m0: strobe in cycle 1, ack in cycle 4
    m0_address = 11'h010; din_v = 32'h0000_A5A5; m0_read = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("rd_strobe", 32'(io_read), 32'(c == 1));
      check("rd_nowrite", 32'(io_write), 32'h0);
      check("rd_ack", 32'(m0_ack), 32'(c == 4));
      check("rd_addr", 32'(io_address), 32'h010);
      if (c == 4) begin
        check("rd_data", m0_data_out, 32'h0000_A5A5);
        m0_read = 1'b0;
      end
    end

    // Single write by m1: address/data/be held through WAIT, ack in cycle 4
    m1_address = 11'h020; m1_data_in = 32'h0000_00FF; m1_be = 4'h1; m1_write = 1'b1;
    din_v = 32'hDEAD_BEEF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("wr_strobe", 32'(io_write), 32'(c == 1));
      check("wr_noread", 32'(io_read), 32'h0);
      check("wr_ack", 32'(m1_ack), 32'(c == 4));
      check("wr_m0_noack", 32'(m0_ack), 32'h0);
      check("wr_addr", 32'(io_address), 32'h020);
      check("wr_dout", io_data_out, 32'h0000_00FF);
      check("wr_be", 32'(io_be), 32'h1);
      check("wr_m0_hold", m0_data_out, 32'h0000_A5A5);
      if (c == 4) m1_write = 1'b0;
    end

    // Contention: last grant was m1, so order is m0,m1,m0,m1 with acks every 5 cycles
    din_mode = 1'b1; m1_be = 4'h0;
    m0_address = 11'h001; m1_address = 11'h002;
    m0_read = 1'b1; m1_read = 1'b1;
    strobes = 0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (io_read) strobes++;
      check("cont_m0_ack", 32'(m0_ack), 32'(c == 4 || c == 14));
      check("cont_m1_ack", 32'(m1_ack), 32'(c == 9 || c == 19));
      if (c == 4 || c == 14) check("cont_m0_data", m0_data_out, 32'h5A00_0001);
      if (c == 9 || c == 19) check("cont_m1_data", m1_data_out, 32'h5A00_0002);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    check("cont_strobes", 32'(strobes), 32'd4);
    @(negedge clk);
    check("cont_idle", 32'({io_read, io_write, m1_ack, m0_ack}), 32'h0);

    // Reset asserted during WAIT drops everything at once and issues no ack
    m0_address = 11'h055; m0_read = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_addr_pre", 32'(io_address), 32'h055);
    rst_n = 1'b0;
    #1;
    check("mid_io_strb", 32'({io_read, io_write}), 32'h0);
    check("mid_io_addr", 32'(io_address), 32'h0);
    check("mid_io_dout", io_data_out, 32'h0);
    check("mid_io_be", 32'(io_be), 32'h0);
    check("mid_acks", 32'({m1_ack, m0_ack}), 32'h0);
    check("mid_m0_dout", m0_data_out, 32'h0);
    check("mid_m1_dout", m1_data_out, 32'h0);
    m0_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'({io_read, io_write, m1_ack, m0_ack}), 32'h0);
    end

    // last_grant back to 1 after reset: m0 wins first contention
    m0_read = 1'b1; m1_read = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("post_rst_m0_ack", 32'(m0_ack), 32'(c == 4));
      check("post_rst_m1_ack", 32'(m1_ack), 32'h0);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES=0: ack two cycles after request, one strobe
    z_m0_address = 11'h400; z_m0_read = 1'b1;
    strobes = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (z_io_read) strobes++;
      check("w0_strobe", 32'(z_io_read), 32'(c == 1));
      check("w0_ack", 32'(z_m0_ack), 32'(c == 2));
      if (c == 2) begin
        check("w0_data", z_m0_data_out, 32'h5A00_0400);
        z_m0_read = 1'b0;
      end
    end
    check("w0_strobes", 32'(strobes), 32'd1);

`ifdef IOARB_LOCK_EN
    // m0 holds the lock for three accesses; m1 waits even though round-robin favours it
    m0_address = 11'h003; m1_address = 11'h004;
    m0_lock = 1'b1; m0_read = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      check("lock_m0_ack", 32'(m0_ack), 32'(c == 4 || c == 9 || c == 14));
      check("lock_m1_ack", 32'(m1_ack), 32'(c == 19));
      if (c == 4) m1_read = 1'b1;
      if (c == 14) m0_lock = 1'b0;
      if (c == 19) check("lock_m1_data", m1_data_out, 32'h5A00_0004);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter and access sequencer in front of the I/O controller's shared read/write bus (11-bit word address, 32-bit data, 4-bit byte enables). It lets the CPU and a second master (DMA/debug) share the UART, switch, SPI and LCD register space. Each access uses a request/acknowledge handshake. Requests are granted round-robin. Every granted access produces exactly one single-cycle strobe, followed by a programmable settle window before read data is captured.

## Interface
- WAIT_CYCLES, default 2: cycles the address is held after the strobe before read data is captured (0–15).
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_read, m0_write  in  1 each  master 0 request; held until m0_ack
- m0_address  in  11  master 0 word address
- m0_data_in  in  32  master 0 write data
- m0_be  in  4  master 0 byte enables
- m0_data_out  out  32  master 0 read data, valid when m0_ack=1
- m0_ack  out  1  master 0 completion pulse
- m1_* : same set as m0_* for master 1
- m0_lock, m1_lock  in  1 each  bus lock request (present only with IOARB_LOCK_EN)
- io_read, io_write  out  1 each  strobes to the I/O controller
- io_address  out  11  to the I/O controller
- io_data_out  out  32  write data to the I/O controller
- io_be  out  4  to the I/O controller
- io_data_in  in  32  read data from the I/O controller (combinational on io_address)

## Operation
- A master is requesting when readX|writeX is high. If both are high, the access is a write and the read is ignored.
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE → STROBE: when any request is present.
  - Select the winner and latch its address, data, be and direction into the io_* registers.
  - last_grant records the winner.
- STROBE (1 cycle): io_read or io_write = 1.
  - Go to WAIT if WAIT_CYCLES>0, else go to DONE.
- WAIT: strobes = 0; io_address, io_data_out and io_be are held.
  - A down-counter is loaded with WAIT_CYCLES−1 on entry.
  - Go to DONE when the counter reaches 0.
- DONE (1 cycle):
  - Capture io_data_in into the winner's mX_data_out. Writes also capture it; the value is don't-care.
  - mX_ack = 1. Return to IDLE.
- Arbitration:
  - A single requester wins.
  - If both request, the master that is not last_grant wins.
  - last_grant resets to 1, so master 0 wins the first contention.
- The losing master's request stays pending, with no ack and no side effects, until it is granted.
- After ack, a master must deassert its request or present a new one. A request still high in the cycle after ack counts as a new access.
- mX_data_out holds its value until that master's next DONE.
- Reset values: io_read=io_write=0, io_address=0, io_data_out=0, io_be=0, m0_ack=m1_ack=0, m0_data_out=m1_data_out=0, state=IDLE, last_grant=1.
- Reset mid-access: strobes and acks drop immediately (asynchronously). No ack is issued for the aborted access.

## Timing
- The request is sampled at edge 0. STROBE occupies cycle 1, WAIT occupies cycles 2..WAIT_CYCLES+1, and ack occurs in cycle WAIT_CYCLES+2.
- Latency from request to ack is WAIT_CYCLES+2 cycles: 4 with the default, 2 with WAIT_CYCLES=0.
- The bus accepts one access every WAIT_CYCLES+3 cycles, because IDLE costs one cycle.
- Back-to-back contention alternates grants strictly: 0,1,0,1…
- Exactly one strobe cycle is issued per access, so UART/SPI FIFO side effects are never doubled.

## Configuration
- Macro: IOARB_LOCK_EN.
- Defined:
  - The mX_lock ports exist.
  - If the granted master's lock is high in DONE, subsequent arbitration grants only that master until its lock is sampled low in IDLE.
  - While locked, the other master's request stays pending.
- Undefined:
  - The lock ports and lock register are absent.
  - Round-robin is applied on every access.

## Structure
- Package io_arb_pkg: state enum (IDLE, STROBE, WAIT, DONE), IO_ADDR_W=11, IO_DATA_W=32, IO_BE_W=4.
- Sub-module io_arb_rr: 2-way round-robin pick.
  - Inputs: req[1:0], last_grant, and lock_owner/lock_valid when locked.
  - Output: the one-hot grant.
  - Purely combinational; the last_grant register stays in the parent.

## Test plan
- Single read: m0 reads 0x010 with io_data_in=0x0000_A5A5 → io_read high only in cycle 1, m0_ack in cycle 4, m0_data_out=0x0000_A5A5.
- Single write: m1 writes 0x020 with data 0x0000_00FF, be=0x1 → io_write for one cycle, io_address=0x020, io_data_out=0xFF, io_be=0x1 held through WAIT, m1_ack in cycle 4.
- Contention: both masters request continuously from reset → grant order 0,1,0,1, one ack every 5 cycles, no master starved.
- WAIT_CYCLES=0: m0 reads 0x400 → ack 2 cycles after request, exactly one strobe.
- Reset mid-access: rst_n asserted during WAIT → io_*, acks and data_out are 0 immediately. After release, state is IDLE and no ack is issued.
- With IOARB_LOCK_EN: m0_lock=1 for three accesses while m1 requests → three m0 grants, then m1 granted in the access after the lock drops.
